prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader sitting directly upstream of the instruction and data memories.
- Replaces the constant-zero load path and the reset-derived loading flag at top level.
- Receives a length-prefixed program image one byte at a time over a valid/ready handshake.
- Packs the payload into 32-bit data-memory writes and 128-bit instruction-memory line writes, then raises done and releases the core.

Parameters:
- ADDR_LEN, 32: width of load_addr.
- BASE_ADDR, 0: byte address of the first payload byte; must be 16-byte aligned.
- MAX_BYTES, 8192: largest accepted payload (512 lines x 16 bytes).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle; a byte transfers when rx_valid & rx_ready at posedge clk.
- load_addr  out  ADDR_LEN  byte address of the current write.
- load_data  out  128  write data; dmem uses [127:96], imem uses all 128 bits.
- we_32  out  1  one-cycle dmem write strobe.
- we_128  out  1  one-cycle imem line write strobe.
- loading  out  1  high until load completes; holds the core in reset.
- done  out  1  load complete, sticky.
- err  out  1  length error, sticky.

Behaviour:
- Reset values: rx_ready=0, load_addr=0, load_data=0, we_32=0, we_128=0, loading=1, done=0, err=0. Reset clears all state, including mid-load; the next image restarts from its header.
- All outputs are registered; rx_ready is decoded from state.
- States:
  - HDR: rx_ready=1. Accepts 4 bytes, little-endian, into len[31:0].
    - After the 4th byte: len==0 -> DONE; len>MAX_BYTES -> ERR; otherwise -> DATA.
  - DATA: rx_ready=1. Each byte goes into the word buffer at lane byte_cnt[1:0], bits [8k+7:8k].
    - A word completes on lane 3 or on the last byte (byte_cnt==len-1); unfilled bytes are zero -> WR32.
  - WR32: rx_ready=0 for one cycle.
    - we_32=1, load_addr=BASE_ADDR+4*word_idx, load_data={word,96'h0}.
    - The word is also stored in line lane word_idx[1:0]. Line lane 0 occupies [127:96] and lane 3 occupies [31:0].
    - Go to WR128 if lane==3 or this is the final word; else back to DATA.
  - WR128: rx_ready=0 for one cycle.
    - we_128=1, load_addr=BASE_ADDR+16*line_idx, load_data=line. Unwritten lanes of a final partial line are zero.
    - Clear the line buffer. Go to DONE if the payload is finished (or to CSUM when the feature is enabled); else back to DATA.
  - DONE: rx_ready=0, done=1, loading=0. Terminal until reset; further bytes are never accepted.
  - ERR: rx_ready=0, err=1, loading stays 1, no further writes. Terminal until reset.
- Latency: the strobe for a completed word occurs the cycle after the completing handshake. The line strobe follows one cycle after that.
- we_32 and we_128 are never asserted in the same cycle. Each payload word produces exactly one we_32.
- Counters: byte_cnt is 32 bits. word_idx and line_idx wrap only within MAX_BYTES, which the length check guarantees.
- rx_valid low stalls the load indefinitely with no output change.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the final WR128, enter CSUM with rx_ready=1 and accept one trailer byte.
  - The trailer must equal the mod-256 sum of all payload bytes. Match -> DONE; mismatch -> ERR.
  - For len==0 the expected sum is 0x00 (HDR -> CSUM).
- Not defined: no trailer byte; the flow is exactly as in Behaviour.

Test Plan:
- Header 08 00 00 00, then bytes 13 00 00 00 93 00 10 00 ->
  - we_32 at addr 0x0 with data[127:96]=0x00000013.
  - we_32 at addr 0x4 with data[127:96]=0x00100093.
  - One we_128 at addr 0x0 with data=0x00000013_00100093_00000000_00000000.
  - Then done=1, loading=0.
- len=16, 16 bytes 0x00..0x0F sent back-to-back ->
  - Four we_32 strobes at 0x0/0x4/0x8/0xC.
  - Single we_128 with data=0x03020100_07060504_0B0A0908_0F0E0D0C.
  - rx_ready low exactly one cycle after each 4th byte and two cycles after the 16th.
- len=5, bytes AA BB CC DD EE ->
  - Second word 0x000000EE at 0x4.
  - we_128 data=0xDDCCBBAA_000000EE_00000000_00000000.
- Header len=0 -> done next cycle, no write strobes. Header len=8193 -> err=1, loading=1, rx_ready=0, no strobes.
- Assert reset after 6 payload bytes of a len=16 image, then send a full new image -> strobes reflect only the new image, addresses restart at BASE_ADDR.
- With LOADER_CHECKSUM_EN: len=2, bytes 01 02, trailer 03 -> done=1. Same image with trailer 04 -> err=1.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Byte-stream program loader. Takes a 4-byte little-endian length
//            header followed by the payload, packs the payload into 32-bit
//            dmem writes and 128-bit imem line writes, then releases the core.
// Options  : LOADER_CHECKSUM_EN - expect one trailer byte holding the mod-256
//            sum of the payload; a mismatch ends in the error state.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int          ADDR_LEN  = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_BYTES = 8192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [ADDR_LEN-1:0] load_addr,
  output logic [127:0]        load_data,
  output logic                we_32,
  output logic                we_128,
  output logic                loading,
  output logic                done,
  output logic                err
);

  // Index widths sized so the counters cover MAX_BYTES without wrapping early.
  localparam int WIDX_W = $clog2(MAX_BYTES / 4 + 1);
  localparam int LIDX_W = $clog2(MAX_BYTES / 16 + 1);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WR32  = 3'd2,
    S_WR128 = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5,
    S_CSUM  = 3'd6
  } state_t;

  state_t              state;
  logic [1:0]          hdr_cnt;
  logic [31:0]         len;
  logic [31:0]         byte_cnt;
  logic [31:0]         word;
  logic [127:0]        line;
  logic [WIDX_W-1:0]   word_idx;
  logic [LIDX_W-1:0]   line_idx;
  logic                final_w;   // the word in flight is the last of the payload
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum;
`endif

  logic                xfer;
  logic [31:0]         len_next;
  logic                last_byte;
  logic [31:0]         word_fill;
  logic [6:0]          lane_lsb;
  logic [ADDR_LEN-1:0] word_addr;
  logic [ADDR_LEN-1:0] line_addr;

  assign xfer      = rx_valid & rx_ready;
  // Header bytes shift in from the top so the first byte ends up in [7:0].
  assign len_next  = {rx_data, len[31:8]};
  assign last_byte = (byte_cnt == len - 32'd1);
  assign word_fill = word | ({24'd0, rx_data} << {byte_cnt[1:0], 3'b000});
  // Line lane 0 sits in the top 32 bits, so the lane offset is inverted.
  assign lane_lsb  = {~word_idx[1:0], 5'b00000};
  assign word_addr = ADDR_LEN'(BASE_ADDR) + ADDR_LEN'({word_idx, 2'b00});
  assign line_addr = ADDR_LEN'(BASE_ADDR) + ADDR_LEN'({line_idx, 4'b0000});

  // Loader state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HDR;
      hdr_cnt   <= 2'd0;
      len       <= 32'd0;
      byte_cnt  <= 32'd0;
      word      <= 32'd0;
      line      <= 128'd0;
      word_idx  <= '0;
      line_idx  <= '0;
      final_w   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
      rx_ready  <= 1'b0;
      load_addr <= '0;
      load_data <= 128'd0;
      we_32     <= 1'b0;
      we_128    <= 1'b0;
      loading   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      we_32  <= 1'b0;
      we_128 <= 1'b0;
      case (state)
        S_HDR: begin
          rx_ready <= 1'b1;
          if (xfer) begin
            len     <= len_next;
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              if (len_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state    <= S_CSUM;
`else
                state    <= S_DONE;
                rx_ready <= 1'b0;
                done     <= 1'b1;
                loading  <= 1'b0;
`endif
              end else if (len_next > 32'(MAX_BYTES)) begin
                state    <= S_ERR;
                rx_ready <= 1'b0;
                err      <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            sum      <= sum + rx_data;
`endif
            if (byte_cnt[1:0] == 2'd3 || last_byte) begin
              word                  <= 32'd0;
              line[lane_lsb +: 32]  <= word_fill;
              we_32                 <= 1'b1;
              load_addr             <= word_addr;
              load_data             <= {word_fill, 96'd0};
              final_w               <= last_byte;
              rx_ready              <= 1'b0;
              state                 <= S_WR32;
            end else begin
              word <= word_fill;
            end
          end
        end

        S_WR32: begin
          word_idx <= word_idx + WIDX_W'(1);
          if (word_idx[1:0] == 2'd3 || final_w) begin
            we_128    <= 1'b1;
            load_addr <= line_addr;
            load_data <= line;
            state     <= S_WR128;
          end else begin
            rx_ready <= 1'b1;
            state    <= S_DATA;
          end
        end

        S_WR128: begin
          line     <= 128'd0;
          line_idx <= line_idx + LIDX_W'(1);
          if (final_w) begin
`ifdef LOADER_CHECKSUM_EN
            rx_ready <= 1'b1;
            state    <= S_CSUM;
`else
            done     <= 1'b1;
            loading  <= 1'b0;
            state    <= S_DONE;
`endif
          end else begin
            rx_ready <= 1'b1;
            state    <= S_DATA;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          rx_ready <= 1'b1;
          if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == sum) begin
              done    <= 1'b1;
              loading <= 1'b0;
              state   <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
`endif

        default: begin
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Randomized and directed bench for prog_loader against a
//            behavioural image-to-writes reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [31:0]  load_addr;
  logic [127:0] load_data;
  logic         we_32;
  logic         we_128;
  logic         loading;
  logic         done;
  logic         err;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .load_addr (load_addr),
    .load_data (load_data),
    .we_32     (we_32),
    .we_128    (we_128),
    .loading   (loading),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit           is_line;
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t        obs[$];
  wr_t        exp_q[$];
  logic [7:0] pay[$];

  // Record every write strobe seen by the memories.
  always @(negedge clk) begin
    wr_t w;
    if (!reset && (we_32 || we_128)) begin
      check("strobe_excl", {127'd0, we_32 & we_128}, 128'd0);
      w.is_line = we_128;
      w.addr    = load_addr;
      w.data    = load_data;
      obs.push_back(w);
    end
  end

  // Reference: the sequence of writes an image must produce.
  task automatic build_exp();
    int           n;
    int           nw;
    logic [31:0]  wd;
    logic [127:0] ln;
    wr_t          w;
    n  = pay.size();
    nw = (n + 3) / 4;
    ln = '0;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      wd = '0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < n) wd[8 * b +: 8] = pay[4 * i + b];
      w.is_line = 1'b0;
      w.addr    = 32'(4 * i);
      w.data    = {wd, 96'd0};
      exp_q.push_back(w);
      ln[(3 - (i % 4)) * 32 +: 32] = wd;
      if (i % 4 == 3 || i == nw - 1) begin
        w.is_line = 1'b1;
        w.addr    = 32'(16 * (i / 4));
        w.data    = ln;
        exp_q.push_back(w);
        ln = '0;
      end
    end
  endtask

  // Cycles rx_ready must be low before payload byte i when sent back-to-back.
  function automatic int exp_stall(input int i);
    if (i == 0) return 0;
    if (i % 16 == 0) return 2;
    if (i % 4 == 0) return 1;
    return 0;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap, output int stalls);
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    stalls   = 0;
    while (!rx_ready && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (!rx_ready) check("ready_timeout", 128'd0, 128'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", {127'd0, rx_ready}, 128'd0);
    check("rst_addr", {96'd0, load_addr}, 128'd0);
    check("rst_data", load_data, 128'd0);
    check("rst_we", {126'd0, we_32, we_128}, 128'd0);
    check("rst_flags", {125'd0, loading, done, err}, 128'd4);
    reset = 1'b0;
    obs.delete();
  endtask

  task automatic send_header(input int n, input bit gap);
    logic [31:0] nn;
    int          st;
    nn = n;
    for (int k = 0; k < 4; k++) send_byte(nn[8 * k +: 8], gap, st);
  endtask

  // Load pay[] as one image and compare the writes and final flags.
  task automatic run_image(input bit gap, input bit bad_sum);
    int         st;
    int         cnt;
    logic [7:0] s;
    bit         exp_err;
    do_reset();
    send_header(pay.size(), gap);
    s = 8'd0;
    for (int i = 0; i < pay.size(); i++) begin
      send_byte(pay[i], gap, st);
      s = s + pay[i];
      if (!gap) check($sformatf("stall_b%0d", i), 128'(st), 128'(exp_stall(i)));
    end
    exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    exp_err = bad_sum;
    send_byte(s + {7'd0, bad_sum}, gap, st);
`else
    if (bad_sum) $display("note: checksum trailer not built in, sum %0h", s);
`endif
    cnt = 0;
    while (!(done || err) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) check("end_timeout", 128'd0, 128'd1);
    repeat (2) @(negedge clk);
    build_exp();
    check("n_writes", 128'(obs.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("wr%0d_kind", i), {127'd0, obs[i].is_line}, {127'd0, exp_q[i].is_line});
      check($sformatf("wr%0d_addr", i), {96'd0, obs[i].addr}, {96'd0, exp_q[i].addr});
      check($sformatf("wr%0d_data", i), obs[i].data, exp_q[i].data);
    end
    check("end_flags", {124'd0, rx_ready, loading, done, err},
          exp_err ? 128'b0101 : 128'b0010);
  endtask

  initial begin
    int          st;
    int          n;
    logic [31:0] lit;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    // Two-word image from the reference program.
    pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_image(1'b0, 1'b0);
    if (obs.size() > 2)
      check("t1_line", obs[2].data, 128'h00000013_00100093_00000000_00000000);

    // One full line sent back-to-back.
    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'(i));
    run_image(1'b0, 1'b0);
    if (obs.size() > 4)
      check("t2_line", obs[4].data, 128'h03020100_07060504_0B0A0908_0F0E0D0C);

    // Partial final word and line.
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_image(1'b0, 1'b0);
    if (obs.size() > 2) begin
      lit = obs[1].data[127:96];
      check("t3_word", {96'd0, lit}, 128'h000000EE);
      check("t3_line", obs[2].data, 128'hDDCCBBAA_000000EE_00000000_00000000);
    end

    // Zero-length image.
    do_reset();
    send_header(0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("len0_ready", {127'd0, rx_ready}, 128'd1);
    send_byte(8'h00, 1'b0, st);
`endif
    check("len0_done", {126'd0, done, loading}, 128'b10);
    check("len0_nowr", 128'(obs.size()), 128'd0);

    // Length one past the limit.
    do_reset();
    send_header(8193, 1'b0);
    rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("big_flags", {124'd0, rx_ready, loading, done, err}, 128'b0101);
    check("big_nowr", 128'(obs.size()), 128'd0);

    // Length exactly at the limit is accepted.
    do_reset();
    send_header(8192, 1'b0);
    check("max_accept", {126'd0, rx_ready, err}, 128'b10);

    // Abort mid-image, then a fresh image must start from the base address.
    do_reset();
    send_header(16, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'hF0 + 8'(i), 1'b0, st);
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
    run_image(1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    pay = '{8'h01, 8'h02};
    run_image(1'b0, 1'b0);
    run_image(1'b0, 1'b1);
`endif

    // Random images, with and without idle gaps on rx_valid.
    for (int t = 0; t < 25; t++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(65, 130) : $urandom_range(1, 40);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      run_image(bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
